bit_serial_addsub: RTL and testbench

//   Parametrised bit-serial adder/subtractor. Latches two WIDTH-bit operands on a start

---
 rtl/bit_serial_addsub.sv | 144 ++++++++++++++
 tb/tb_bit_serial_addsub.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_addsub.sv
// rtl/bit_serial_addsub.sv - bit-serial adder/subtractor, one full-adder bit per clock, LSB first
module bit_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_s;
    logic             carry_nxt;
    logic             last_bit;

    // Full adder on the current LSBs; carry_q is the carry into this bit
    assign bit_s     = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    assign carry_nxt = (op_a_q[0] & op_b_q[0]) | (carry_q & (op_a_q[0] ^ op_b_q[0]));
    assign last_bit  = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the MSB, DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered status outputs follow the state being entered
    always_comb begin
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // Datapath: operand load, serial add/shift, and result capture on the final bit
    always_comb begin
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
                op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
                acc_d   = {bit_s, acc_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // Overflow: carry into the MSB differs from carry out of it
                    sum_d  = {bit_s, acc_q[WIDTH-1:1]};
                    cout_d = carry_nxt;
                    ovf_d  = carry_q ^ carry_nxt;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers, all cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// tb/tb_bit_serial_addsub.sv - randomized, model-checked bench for bit_serial_addsub (WIDTH 8 and 4)
module tb_bit_serial_addsub;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    bit_serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: {cout, ovf, sum[15:0]} from signed/unsigned integer ranges
    function automatic logic [17:0] ref_res(input int av, input int bv, input bit s, input int w);
        int full, sa, sb, sr, raw;
        logic [17:0] r;
        full = 1 << w;
        sa   = (av >= full / 2) ? av - full : av;
        sb   = (bv >= full / 2) ? bv - full : bv;
        sr   = s ? sa - sb : sa + sb;
        raw  = s ? av - bv : av + bv;
        r[15:0] = 16'(((raw % full) + full) % full);
        r[16]   = (sr < -(full / 2)) || (sr > full / 2 - 1);
        r[17]   = s ? (av >= bv) : (av + bv >= full);
        return r;
    endfunction

    // Timeline model: phase 0 idle, 1..W busy, W+1 done; results appear on entering done
    int          ph8, ph4;
    logic [17:0] pend8, pend4;
    logic [7:0]  m_sum8;
    logic [3:0]  m_sum4;
    logic        m_cout8, m_ovf8, m_cout4, m_ovf4;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph8 <= 0; m_sum8 <= '0; m_cout8 <= 1'b0; m_ovf8 <= 1'b0; pend8 <= '0;
        end else if (ph8 == 0) begin
            if (start8) begin
                ph8   <= 1;
                pend8 <= ref_res(int'(a8), int'(b8), sub8, 8);
            end
        end else if (ph8 == 8) begin
            ph8 <= 9; m_sum8 <= pend8[7:0]; m_ovf8 <= pend8[16]; m_cout8 <= pend8[17];
        end else if (ph8 == 9) begin
            ph8 <= 0;
        end else begin
            ph8 <= ph8 + 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph4 <= 0; m_sum4 <= '0; m_cout4 <= 1'b0; m_ovf4 <= 1'b0; pend4 <= '0;
        end else if (ph4 == 0) begin
            if (start4) begin
                ph4   <= 1;
                pend4 <= ref_res(int'(a4), int'(b4), sub4, 4);
            end
        end else if (ph4 == 4) begin
            ph4 <= 5; m_sum4 <= pend4[3:0]; m_ovf4 <= pend4[16]; m_cout4 <= pend4[17];
        end else if (ph4 == 5) begin
            ph4 <= 0;
        end else begin
            ph4 <= ph4 + 1;
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        chk("busy8", busy8, (ph8 >= 1 && ph8 <= 8));
        chk("done8", done8, (ph8 == 9));
        chk("sum8",  sum8,  m_sum8);
        chk("cout8", cout8, m_cout8);
        chk("ovf8",  ovf8,  m_ovf8);
        chk("busy4", busy4, (ph4 >= 1 && ph4 <= 4));
        chk("done4", done4, (ph4 == 5));
        chk("sum4",  sum4,  m_sum4);
        chk("cout4", cout4, m_cout4);
        chk("ovf4",  ovf4,  m_ovf4);
    end

    // Record the cycle at which busy rises on the 8-bit instance
    int cyc = 0;
    logic busy8_prev = 1'b0;
    int rise_q[$];
    always @(negedge clk) begin
        cyc++;
        if (busy8 === 1'b1 && busy8_prev !== 1'b1) rise_q.push_back(cyc);
        busy8_prev = busy8;
    end

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic s, input bit lit,
                        input logic [7:0] es, input logic ec, input logic eo);
        int  n_busy = 0;
        bit  seen = 0;
        @(negedge clk);
        a8 = av; b8 = bv; sub8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy8) n_busy++;
            if (done8) seen = 1;
            else begin
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
                start8 = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        start8 = 1'b0;
        chk("done8_seen", seen, 1);
        chk("busy8_cycles", n_busy, 8);
        if (lit) begin
            chk("lit_sum8", sum8, es);
            chk("lit_cout8", cout8, ec);
            chk("lit_ovf8", ovf8, eo);
            chk("model_sum8", m_sum8, es);
            chk("model_cout8", m_cout8, ec);
            chk("model_ovf8", m_ovf8, eo);
        end
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic s, input bit lit,
                        input logic [3:0] es, input logic ec, input logic eo);
        int  n_busy = 0;
        bit  seen = 0;
        @(negedge clk);
        a4 = av; b4 = bv; sub4 = s; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy4) n_busy++;
            if (done4) seen = 1;
            else begin
                a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom);
                start4 = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        start4 = 1'b0;
        chk("done4_seen", seen, 1);
        chk("busy4_cycles", n_busy, 4);
        if (lit) begin
            chk("lit_sum4", sum4, es);
            chk("lit_cout4", cout4, ec);
            chk("lit_ovf4", ovf4, eo);
            chk("model_sum4", m_sum4, es);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        // Reset pulse between clock edges
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        chk("rst_ovf", ovf8, 0);
        #1 rst = 1'b0;

        // Directed arithmetic cases
        run8(8'h5A, 8'h33, 1'b0, 1, 8'h8D, 1'b0, 1'b1);
        run8(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b0);
        run8(8'h7F, 8'h7F, 1'b0, 1, 8'hFE, 1'b0, 1'b1);
        run8(8'h10, 8'h20, 1'b1, 1, 8'hF0, 1'b0, 1'b0);
        run8(8'h80, 8'h01, 1'b1, 1, 8'h7F, 1'b1, 1'b1);

        // start held high over three operations, operands churned mid-operation
        @(negedge clk);
        rise_q.delete();
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        chk("hold_accepts", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            chk("hold_gap1", rise_q[1] - rise_q[0], 10);
            chk("hold_gap2", rise_q[2] - rise_q[1], 10);
        end

        // Abort after three SHIFT edges
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h41; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_cout", cout8, 0);
        chk("abort_ovf", ovf8, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        run8(8'h3C, 8'h41, 1'b0, 1, 8'h7D, 1'b0, 1'b0);

        // Width 4
        run4(4'h9, 4'h8, 1'b0, 1, 4'h1, 1'b1, 1'b1);

        // Randomized operations on both widths
        for (int i = 0; i < 30; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            run4(4'($urandom), 4'($urandom), 1'($urandom), 0, 4'h0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
